// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding and
// prescaler sizing helpers.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_LAP,
    ST_EXPIRED
  } state_e;

  function automatic int unsigned calc_div(input int unsigned board_hz,
                                           input int unsigned tick_hz);
    return board_hz / tick_hz;
  endfunction

  function automatic int unsigned calc_prescaler_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_generator.sv
// Timebase prescaler: counts 0..DIV-1 while run is high and flags the wrap
// cycle on tick; clear returns it to phase 0 and suppresses that cycle's tick.
module tick_generator
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = calc_prescaler_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  assign tick = run && !clear && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing: button edge decode, run/pause/lap/expiry FSM, counter
// controls and display freeze. Lap support is built only with STOPWATCH_LAP_EN.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUMBER_OF_DIGITS            = 4,
  parameter int unsigned NUMBER_OF_BITS_PER_DIGIT    = 4,
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned TICK_FREQUENCY_IN_HZ        = 100,
  localparam int unsigned W = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_start_stop,
  input  logic         btn_lap,
  input  logic         btn_clear,
  input  logic         count_down,
  input  logic [W-1:0] preset,
  input  logic [W-1:0] counter_number,
  output logic         counter_enable,
  output logic         counter_up_down,
  output logic         counter_set,
  output logic [W-1:0] counter_set_value,
  output logic [W-1:0] display_number,
  output logic         running,
  output logic         lap_active,
  output logic         expired
);

  localparam int unsigned DIV = calc_div(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_FREQUENCY_IN_HZ);

  state_e       state_q, state_d;
  logic         ss_prev_q, clr_prev_q;
  logic         up_down_q, up_down_d;
  logic         enable_q, enable_d;
  logic         set_q, set_d;
  logic [W-1:0] set_value_q, set_value_d;
  logic [W-1:0] display_q, display_d;
  logic         running_q, expired_q;
  logic         ss_press, clr_press, lap_press;
  logic         tick, active, idle_or_paused, down_mode, zero, expire;

  assign ss_press  = btn_start_stop & ~ss_prev_q;
  assign clr_press = btn_clear & ~clr_prev_q;

`ifdef STOPWATCH_LAP_EN
  logic         lap_prev_q, lap_active_q;
  logic [W-1:0] lap_q, lap_d;
  assign lap_press  = btn_lap & ~lap_prev_q;
  assign lap_active = lap_active_q;
`else
  // Lap button has no function in this build.
  logic lap_unused;
  assign lap_unused = btn_lap;
  assign lap_press  = 1'b0;
  assign lap_active = 1'b0;
`endif

  assign active         = (state_q == ST_RUNNING) || (state_q == ST_LAP);
  assign idle_or_paused = (state_q == ST_IDLE) || (state_q == ST_PAUSED);
  // Direction is live while stopped, otherwise the latched value governs.
  assign down_mode      = idle_or_paused ? count_down : ~up_down_q;
  assign zero           = (counter_number == '0);
  assign expire         = tick && down_mode && zero;

  tick_generator #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (active),
    .clear(clr_press),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    up_down_d   = up_down_q;
    enable_d    = tick && !(down_mode && zero);
    set_d       = 1'b0;
    set_value_d = '0;
    display_d   = counter_number;
`ifdef STOPWATCH_LAP_EN
    lap_d = lap_q;
    if (state_q == ST_LAP) display_d = lap_q;
`endif
    if (idle_or_paused) up_down_d = ~count_down;

    if (clr_press) begin
      state_d     = ST_IDLE;
      set_d       = 1'b1;
      set_value_d = down_mode ? preset : '0;
    end else if (expire) begin
      state_d = ST_EXPIRED;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_PAUSED: begin
          if (ss_press && !(down_mode && zero)) state_d = ST_RUNNING;
        end
        ST_RUNNING, ST_LAP: begin
          if (ss_press) begin
            state_d = ST_PAUSED;
          end else if (lap_press) begin
            state_d = ST_LAP;
`ifdef STOPWATCH_LAP_EN
            lap_d = counter_number;
`endif
          end
        end
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ss_prev_q   <= 1'b1;
      clr_prev_q  <= 1'b1;
      up_down_q   <= 1'b1;
      enable_q    <= 1'b0;
      set_q       <= 1'b0;
      set_value_q <= '0;
      display_q   <= '0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_prev_q   <= btn_start_stop;
      clr_prev_q  <= btn_clear;
      up_down_q   <= up_down_d;
      enable_q    <= enable_d;
      set_q       <= set_d;
      set_value_q <= set_value_d;
      display_q   <= display_d;
      running_q   <= (state_d == ST_RUNNING) || (state_d == ST_LAP);
      expired_q   <= (state_d == ST_EXPIRED);
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_prev_q   <= 1'b1;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else begin
      lap_prev_q   <= btn_lap;
      lap_q        <= lap_d;
      lap_active_q <= (state_d == ST_LAP);
    end
  end
`endif

  assign counter_enable    = enable_q;
  assign counter_up_down   = up_down_q;
  assign counter_set       = set_q;
  assign counter_set_value = set_value_q;
  assign display_number    = display_q;
  assign running           = running_q;
  assign expired           = expired_q;

endmodule
